// File: rtl/lib_pkg.sv
// Shared types for the fetch/decode front end: opcode constants, the decoded
// instruction record, immediate formats and the fetch FSM states.
package lib_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISCMEM, SYSTEM
  } op_type_t;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} imm_fmt_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

  typedef struct packed {
    op_type_t    op_type;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } decoded_t;

  localparam decoded_t DEC_RESET = '{op_type: MISCMEM, funct3: 3'd0, funct7: 7'd0,
                                     rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                                     imm: 32'd0, illegal: 1'b0};

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decoder: splits a 32-bit instruction word into the fields the
// controller consumes and builds the sign-extended immediate.
module instr_decode
  import lib_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  imm_fmt_t fmt;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    dec.op_type = MISCMEM;
    dec.illegal = 1'b0;
    fmt         = FMT_NONE;
    dec.funct3  = instr[14:12];
    dec.funct7  = instr[31:25];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    case (instr[6:0])
      OPC_LUI:     begin dec.op_type = LUI;     fmt = FMT_U;    end
      OPC_AUIPC:   begin dec.op_type = AUIPC;   fmt = FMT_U;    end
      OPC_JAL:     begin dec.op_type = JAL;     fmt = FMT_J;    end
      OPC_JALR:    begin dec.op_type = JALR;    fmt = FMT_I;    end
      OPC_BRANCH:  begin dec.op_type = BRANCH;  fmt = FMT_B;    end
      OPC_LOAD:    begin dec.op_type = LOAD;    fmt = FMT_I;    end
      OPC_STORE:   begin dec.op_type = STORE;   fmt = FMT_S;    end
      OPC_OPIMM:   begin dec.op_type = OPIMM;   fmt = FMT_I;    end
      OPC_OP:      begin dec.op_type = OP;      fmt = FMT_NONE; end
      OPC_MISCMEM: begin dec.op_type = MISCMEM; fmt = FMT_I;    end
      OPC_SYSTEM:  begin dec.op_type = SYSTEM;  fmt = FMT_I;    end
      // Unknown opcodes look like a MISCMEM no-op so the controller issues no writes.
      default:     begin dec.op_type = MISCMEM; dec.illegal = 1'b1; end
    endcase
    dec.imm = gen_imm(instr, fmt);
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: owns the PC, issues one instruction-memory request at a time,
// registers the decoded word and holds it until execute consumes it.
module instr_fetch
  import lib_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output op_type_t        op_type,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic            instr_valid_q, instr_valid_d;
  decoded_t        dec_q, dec_d, dec_w;

  instr_decode u_decode (
    .instr (imem_rsp_data),
    .dec   (dec_w)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_valid_d   = req_valid_q;
    instr_valid_d = instr_valid_q;
    dec_d         = dec_q;
    case (state_q)
      IDLE: begin
        state_d     = REQ;
        req_valid_d = 1'b1;
      end
      REQ: if (imem_req_ready) begin
        state_d     = WAIT;
        req_valid_d = 1'b0;
      end
      WAIT: if (imem_rsp_valid) begin
        state_d       = HOLD;
        instr_valid_d = 1'b1;
        dec_d         = dec_w;
      end
      HOLD: if (instr_ready) begin
        // Redirect is only meaningful on the consume handshake; pc+4 wraps naturally.
        state_d       = REQ;
        instr_valid_d = 1'b0;
        req_valid_d   = 1'b1;
        pc_d          = redirect_valid ? (redirect_pc & ALIGN_MASK) : pc_q + XLEN'(4);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, and all state updates use non-blocking assignments.
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      dec_q         <= DEC_RESET;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
      dec_q         <= dec_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign op_type        = dec_q.op_type;
  assign funct3         = dec_q.funct3;
  assign funct7         = dec_q.funct7;
  assign rs1            = dec_q.rs1;
  assign rs2            = dec_q.rs2;
  assign rd             = dec_q.rd;
  assign imm            = XLEN'($signed(dec_q.imm));
  assign illegal        = dec_q.illegal;

endmodule
